// File: rtl/uart_tx_ctrl.sv
// UART transmit framing controller: byte handshake, baud timing, PISO load/shift
// strobes and start/data/parity/stop multiplexing onto the serial line.
module uart_tx_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             piso_bit,
  output logic             load_bit,
  output logic             shift_bit,
  output logic             tx,
  output logic             busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic             ODD_BIT  = (PARITY_ODD != 0);
  localparam logic             HAS_PAR  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             parity_q, parity_d;

  logic bit_done;
  logic accept;

  assign bit_done = (baud_cnt_q == CNT_LAST);
  assign tx_ready = (state_q == IDLE) && rst;
  assign accept   = tx_valid && tx_ready;
  assign load_bit = accept;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      parity_q   <= parity_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    parity_d   = parity_q;
    shift_bit  = 1'b0;
    tx         = 1'b1;
    // Free-running bit timer in every framed state; held at zero while idle.
    if (state_q == IDLE || bit_done) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = START;
          parity_d = (^tx_data) ^ ODD_BIT;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        // The shifter already presents the current bit; advance it only
        // between data bits, never after the last one.
        tx = piso_bit;
        if (bit_done) begin
          if (bit_idx_q != IDX_LAST) begin
            shift_bit = 1'b1;
            bit_idx_d = bit_idx_q + 1'b1;
          end else begin
            state_d = HAS_PAR ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        tx = parity_q;
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three configurations (even, odd, no parity) driven with
// directed and random bytes, checked cycle by cycle against an expected frame.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
  localparam int W   = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata  [3];
  logic       tvalid [3];
  logic       tready [3];
  logic       load   [3];
  logic       shift  [3];
  logic       txo    [3];
  logic       busyo  [3];
  logic [7:0] sh     [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst(rst), .tx_data(tdata[0]), .tx_valid(tvalid[0]), .tx_ready(tready[0]),
    .piso_bit(sh[0][0]), .load_bit(load[0]), .shift_bit(shift[0]), .tx(txo[0]), .busy(busyo[0]));

  uart_tx_ctrl #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_data(tdata[1]), .tx_valid(tvalid[1]), .tx_ready(tready[1]),
    .piso_bit(sh[1][0]), .load_bit(load[1]), .shift_bit(shift[1]), .tx(txo[1]), .busy(busyo[1]));

  uart_tx_ctrl #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
    .clk(clk), .rst(rst), .tx_data(tdata[2]), .tx_valid(tvalid[2]), .tx_ready(tready[2]),
    .piso_bit(sh[2][0]), .load_bit(load[2]), .shift_bit(shift[2]), .tx(txo[2]), .busy(busyo[2]));

  // Downstream parallel-in serial-out shifter, one per controller.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (load[k])       sh[k] <= tdata[k];
      else if (shift[k]) sh[k] <= sh[k] >> 1;
    end
  end

  function automatic int pe_of(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic logic po_of(input int k);
    return (k == 1) ? 1'b1 : 1'b0;
  endfunction

  // Serial line value for frame slot: start, LSB-first data, optional parity, stop.
  function automatic logic exp_bit(input int k, input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= W) return b[slot-1];
    if (pe_of(k) == 1 && slot == W + 1) return (^b) ^ po_of(k);
    return 1'b1;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Waits (bounded) for ready, presents the byte and returns on the accept edge.
  task automatic send(input int k, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    tvalid[k] = 1'b0;
    while (!tready[k] && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk1("ready_wait", tready[k], 1'b1);
    tdata[k]  = b;
    tvalid[k] = 1'b1;
    #1;
    chk1("load_on_accept", load[k], 1'b1);
    @(posedge clk);
  endtask

  // Checks ncyc cycles of a frame (0 = whole frame) starting the cycle after accept.
  task automatic frame(input int k, input logic [7:0] b, input bit hold, input int ncyc);
    int full   = (2 + W + pe_of(k)) * CPB;
    int n      = (ncyc == 0) ? full : ncyc;
    int shifts = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!hold) begin
        tvalid[k] = 1'($urandom_range(0, 1));
        tdata[k]  = 8'($urandom);
      end
      #1;
      chk1("tx_bit", txo[k], exp_bit(k, b, c / CPB));
      chk1("busy_in_frame", busyo[k], 1'b1);
      chk1("ready_in_frame", tready[k], 1'b0);
      chk1("load_in_frame", load[k], 1'b0);
      if (shift[k]) shifts++;
    end
    if (ncyc == 0) chkn("shift_count", shifts, W - 1);
  endtask

  task automatic idle_chk(input int k);
    @(negedge clk);
    tvalid[k] = 1'b0;
    #1;
    chk1("idle_tx", txo[k], 1'b1);
    chk1("idle_busy", busyo[k], 1'b0);
    chk1("idle_ready", tready[k], 1'b1);
    chk1("idle_load", load[k], 1'b0);
  endtask

  task automatic full_frame(input int k, input logic [7:0] b);
    send(k, b);
    frame(k, b, 1'b0, 0);
    idle_chk(k);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tvalid[k] = 1'b0;
      tdata[k]  = 8'h00;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk1("rst_tx", txo[k], 1'b1);
      chk1("rst_busy", busyo[k], 1'b0);
      chk1("rst_ready", tready[k], 1'b0);
      chk1("rst_load", load[k], 1'b0);
      chk1("rst_shift", shift[k], 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk1("post_rst_ready", tready[k], 1'b1);

    // Directed frames: 0xA5 even, parity corners, no-parity frame
    full_frame(0, 8'hA5);
    full_frame(0, 8'h01);
    full_frame(1, 8'h01);
    full_frame(0, 8'hFF);
    full_frame(2, 8'h3C);

    // Back-to-back with tx_valid held high
    @(negedge clk);
    tdata[0]  = 8'h55;
    tvalid[0] = 1'b1;
    #1;
    chk1("b2b_load_first", load[0], 1'b1);
    @(posedge clk);
    #1;
    tdata[0] = 8'hAA;
    frame(0, 8'h55, 1'b1, 0);
    @(negedge clk);
    #1;
    chk1("b2b_gap_tx", txo[0], 1'b1);
    chk1("b2b_gap_busy", busyo[0], 1'b0);
    chk1("b2b_gap_ready", tready[0], 1'b1);
    chk1("b2b_load_second", load[0], 1'b1);
    @(posedge clk);
    frame(0, 8'hAA, 1'b0, 0);
    idle_chk(0);

    // Reset during data bit 3 of 0xF0, then a clean 0x0F
    send(0, 8'hF0);
    frame(0, 8'hF0, 1'b0, 17);
    @(negedge clk);
    tvalid[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk1("midrst_ready_low", tready[0], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("midrst_tx", txo[0], 1'b1);
    chk1("midrst_busy", busyo[0], 1'b0);
    chk1("midrst_ready", tready[0], 1'b1);
    full_frame(0, 8'h0F);

    // Reset held low with tx_valid asserted
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tvalid[k] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk1("hold_rst_ready", tready[k], 1'b0);
        chk1("hold_rst_load", load[k], 1'b0);
        chk1("hold_rst_tx", txo[k], 1'b1);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) tvalid[k] = 1'b0;
    rst = 1'b1;

    // Random bytes on every configuration with random idle gaps
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) begin
        rb = 8'($urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        full_frame(k, rb);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Framing controller for the UART transmitter. It accepts a parallel byte over a valid/ready handshake and generates the baud timing. It drives the load/shift strobes of the downstream parallel-in serial-out shifter and muxes start, data, parity and stop bits onto the serial line. The shifter's data input is wired to tx_data. The shifter's LSB output returns to this block as piso_bit.

Parameters:
WIDTH, 8, data bits per frame; must match the shifter width.
CLKS_PER_BIT, 868, clk cycles per serial bit (minimum 2).
PARITY_EN, 1, 1 = append a parity bit after the data bits; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-low
tx_data  in  WIDTH  byte to send; also wired to the shifter data input
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller can accept a byte
piso_bit  in  1  current data bit from the shifter (its LSB)
load_bit  out  1  shifter load strobe
shift_bit  out  1  shifter shift-right strobe
tx  out  1  serial line, idle high
busy  out  1  frame in progress

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (rst=0 at a clk edge): state=IDLE, baud_cnt=0, bit_idx=0, parity_reg=0. After that edge: tx=1, busy=0, load_bit=0, shift_bit=0.
- tx_ready is forced to 0 while rst=0.
- Reset mid-frame aborts the frame. tx returns to 1 on the cycle after the reset edge. No partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready = (state==IDLE) && rst.
- busy = (state!=IDLE).
- Accept = tx_valid && tx_ready. load_bit = accept (combinational), so the shifter captures tx_data on the accept edge.
- tx_valid while not ready is ignored. No data is latched in that case.
- On the accept edge:
  - state becomes START and baud_cnt clears to 0.
  - parity_reg latches XOR-reduce(tx_data) XOR PARITY_ODD.
- Baud timing:
  - baud_cnt counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - bit_done = (baud_cnt==CLKS_PER_BIT-1); baud_cnt wraps to 0 on bit_done.
  - Every bit period lasts exactly CLKS_PER_BIT cycles.
- START: tx=0. On bit_done, go to DATA with bit_idx=0.
- DATA: tx=piso_bit, data sent LSB first.
  - On bit_done with bit_idx<WIDTH-1: shift_bit=1 for exactly that one cycle, and bit_idx increments.
  - On bit_done with bit_idx==WIDTH-1: no shift. Go to PARITY if PARITY_EN, else STOP.
  - Exactly WIDTH-1 shift pulses per frame.
- PARITY: tx=parity_reg. On bit_done, go to STOP.
- STOP: tx=1. On bit_done, go to IDLE.
- tx is a mux of registered state, parity_reg and the registered shifter output. There is no combinational path from tx_valid or tx_data to tx.
- Frame length: (2 + WIDTH + PARITY_EN) × CLKS_PER_BIT cycles, from the cycle after accept to the return to IDLE.
- Back-to-back frames:
  - tx_ready rises in the first IDLE cycle; accept is possible on that edge.
  - Minimum line idle between frames is therefore 1 clk (the stop bit is stretched by 1 cycle).
- load_bit and shift_bit are never high in the same cycle.

Test Plan:
1. WIDTH=8, CLKS_PER_BIT=4, even parity; send 0xA5 -> tx sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 0(parity), 1. Frame is 44 cycles, load_bit pulses once, shift_bit pulses 7 times. tx_ready is low through the frame and high after.
2. Same config, send 0x01 with even parity, then 0x01 with PARITY_ODD=1 -> parity bit 1 for even, 0 for odd. Send 0xFF with even parity -> parity bit 0.
3. PARITY_EN=0; send 0x3C -> tx: 0, 0,0,1,1,1,1,0,0, 1. Frame is 40 cycles, no parity slot.
4. tx_valid held high continuously with tx_data=0x55 then 0xAA -> second accept occurs in the first IDLE cycle after the first stop bit. Exactly 1 extra high cycle between frames. tx_valid pulses while busy cause no load_bit.
5. Assert rst=0 for one cycle during DATA bit 3 of 0xF0 -> tx=1, busy=0, tx_ready=1 on the cycle after rst deasserts. A new byte 0x0F then transmits correctly.
6. Reset held low with tx_valid=1 -> tx_ready=0, load_bit=0, tx=1 for the entire reset window.
